// File: rtl/dm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dm_pkg                                                      |
// | Purpose : Shared types for the data-memory load/store unit: request   |
// |           op encodings, FSM state encoding and small op helpers.      |
// | Ports   : none (package)                                              |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package dm_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage : dm_pkg
`default_nettype wire

// File: rtl/dm_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dm_lane                                                     |
// | Purpose : Purely combinational byte-lane steering. Maps an op and     |
// |           the low address bits to byte enables, lane-replicated       |
// |           write data, the extended load result and a misalignment     |
// |           flag.                                                       |
// | Ports   : op        - request op                                      |
// |           addr_lo   - byte address bits [1:0]                         |
// |           wdata     - right-aligned store data                        |
// |           rd        - memory read word                                |
// |           be        - byte enables (stores only, 0 for loads)         |
// |           wd        - write data replicated across lanes              |
// |           load_data - selected and extended load result              |
// |           misaligned- word/halfword access not naturally aligned     |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module dm_lane
  import dm_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rd,
  output logic [3:0]  be,
  output logic [31:0] wd,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = rd[8*addr_lo +: 8];
    rd_half = addr_lo[1] ? rd[31:16] : rd[15:0];
  end

  always_comb begin
    be         = 4'b0000;
    wd         = 32'd0;
    load_data  = 32'd0;
    misaligned = 1'b0;
    case (op)
      OP_LW: begin
        load_data  = rd;
        misaligned = (addr_lo != 2'b00);
      end
      OP_LH: begin
        load_data  = {{16{rd_half[15]}}, rd_half};
        misaligned = addr_lo[0];
      end
      OP_LHU: begin
        load_data  = {16'd0, rd_half};
        misaligned = addr_lo[0];
      end
      OP_LB:  load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU: load_data = {24'd0, rd_byte};
      OP_SW: begin
        be         = 4'b1111;
        wd         = wdata;
        misaligned = (addr_lo != 2'b00);
      end
      OP_SH: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wd         = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      OP_SB: begin
        be = 4'b0001 << addr_lo;
        wd = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule : dm_lane
`default_nettype wire

// File: rtl/dm_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dm_lsu                                                      |
// | Purpose : Load/store unit in front of a word-addressed data memory   |
// |           with combinational read. Three-state FSM: IDLE accepts a    |
// |           request, ACCESS drives the memory for exactly one cycle,    |
// |           RESP holds the response until the consumer takes it.        |
// | Ports   : Clk, Reset           - clock, synchronous active-high reset |
// |           req_valid/ready/op/addr/wdata - request handshake          |
// |           rsp_valid/ready/rdata/err     - response handshake         |
// |           A, BE, WD, We        - memory word address, byte enables,  |
// |                                  write data, write enable            |
// |           RD                   - memory read data (comb. from A)     |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module dm_lsu
  import dm_pkg::*;
#(
  parameter int ADDR_HI = 12
)
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_HI-2:0] A,
  output logic [3:0]        BE,
  output logic [31:0]       WD,
  output logic              We,
  input  logic [31:0]       RD
);

  state_e      state;
  op_e         op_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic [31:0] lane_load;
  logic        lane_misaligned;
  logic        out_of_range;
  logic        err;
  logic        access;
  logic        do_write;

  dm_lane u_lane (
    .op         (op_r),
    .addr_lo    (addr_r[1:0]),
    .wdata      (wdata_r),
    .rd         (RD),
    .be         (lane_be),
    .wd         (lane_wd),
    .load_data  (lane_load),
    .misaligned (lane_misaligned)
  );

  always_comb begin
    out_of_range = ((addr_r >> (ADDR_HI + 1)) != 32'd0);
    err          = lane_misaligned || out_of_range;
    // Reset gates the memory port combinationally so a write landing in
    // the same cycle as Reset never reaches the memory.
    access       = (state == ST_ACCESS) && !Reset;
    do_write     = access && is_store(op_r) && !err;
  end

  always_comb begin
    req_ready = (state == ST_IDLE) || Reset;
    rsp_valid = (state == ST_RESP) && !Reset;
    A         = access ? addr_r[ADDR_HI:2] : '0;
    We        = do_write;
    BE        = do_write ? lane_be : 4'b0000;
    WD        = do_write ? lane_wd : 32'd0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      op_r      <= OP_LW;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_r    <= op_e'(req_op);
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rsp_err   <= err;
          rsp_rdata <= (err || is_store(op_r)) ? 32'd0 : lane_load;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : dm_lsu
`default_nettype wire

// File: tb/tb_dm_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dm_lsu                                                   |
// | Purpose : Self-checking bench for dm_lsu: directed vector table plus  |
// |           hand-written back-pressure and reset sequences, with a      |
// |           behavioural byte-enabled memory.                            |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_dm_lsu;

  localparam int ADDR_HI = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_HI-2:0] mem_a;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wd;
  logic              mem_we;
  logic [31:0]       mem_rd;

  logic [31:0] mem [0:2047];
  int          we_cnt = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  dm_lsu #(.ADDR_HI(ADDR_HI)) dut (
    .Clk       (clk),
    .Reset     (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .A         (mem_a),
    .BE        (mem_be),
    .WD        (mem_wd),
    .We        (mem_we),
    .RD        (mem_rd)
  );

  assign mem_rd = mem[mem_a];

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_a][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input logic [3:0] be,
                              input logic [31:0] wd, input logic we);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.err = err; v.be = be; v.wd = wd; v.we = we;
    return v;
  endfunction

  // One full request: drive, accept at edge N, check ACCESS in N+1 and the
  // response in N+2, then retire it.
  task automatic run_vec(input vec_t v, input int idx);
    int we0;
    chk($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk($sformatf("v%0d access rsp_valid", idx), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d We", idx), {31'd0, mem_we}, {31'd0, v.we});
    chk($sformatf("v%0d BE", idx), {28'd0, mem_be}, {28'd0, v.be});
    chk($sformatf("v%0d WD", idx), mem_wd, v.wd);
    chk($sformatf("v%0d A", idx), {21'd0, mem_a}, {21'd0, v.addr[12:2]});
    @(posedge clk); #1;
    chk($sformatf("v%0d rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.rdata);
    chk($sformatf("v%0d rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.err});
    chk($sformatf("v%0d write count", idx), we_cnt - we0, v.we ? 32'd1 : 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk($sformatf("v%0d back to idle", idx), {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int          we0;

    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; rsp_ready = 1'b0;

    //             op   addr        wdata        rdata        err  be       wd           we
    vecs[0]  = mk(3'd5, 32'h10, 32'h12345678, 32'h0,        0, 4'b1111, 32'h12345678, 1);
    vecs[1]  = mk(3'd0, 32'h10, 32'h0,        32'h12345678, 0, 4'b0000, 32'h0,        0);
    vecs[2]  = mk(3'd7, 32'h13, 32'h000000AB, 32'h0,        0, 4'b1000, 32'hABABABAB, 1);
    vecs[3]  = mk(3'd3, 32'h13, 32'h0,        32'hFFFFFFAB, 0, 4'b0000, 32'h0,        0);
    vecs[4]  = mk(3'd4, 32'h13, 32'h0,        32'h000000AB, 0, 4'b0000, 32'h0,        0);
    vecs[5]  = mk(3'd6, 32'h22, 32'h12348001, 32'h0,        0, 4'b1100, 32'h80018001, 1);
    vecs[6]  = mk(3'd1, 32'h22, 32'h0,        32'hFFFF8001, 0, 4'b0000, 32'h0,        0);
    vecs[7]  = mk(3'd2, 32'h22, 32'h0,        32'h00008001, 0, 4'b0000, 32'h0,        0);
    vecs[8]  = mk(3'd3, 32'h23, 32'h0,        32'hFFFFFF80, 0, 4'b0000, 32'h0,        0);
    vecs[9]  = mk(3'd1, 32'h20, 32'h0,        32'h00000000, 0, 4'b0000, 32'h0,        0);
    vecs[10] = mk(3'd7, 32'h11, 32'h1234565A, 32'h0,        0, 4'b0010, 32'h5A5A5A5A, 1);
    vecs[11] = mk(3'd0, 32'h10, 32'h0,        32'hAB345A78, 0, 4'b0000, 32'h0,        0);
    vecs[12] = mk(3'd0, 32'h6,  32'h0,        32'h0,        1, 4'b0000, 32'h0,        0);
    vecs[13] = mk(3'd6, 32'h5,  32'h1234,     32'h0,        1, 4'b0000, 32'h0,        0);
    vecs[14] = mk(3'd5, 32'h2000, 32'hDEADBEEF, 32'h0,      1, 4'b0000, 32'h0,        0);
    vecs[15] = mk(3'd4, 32'h1FFF, 32'h0,      32'h0,        0, 4'b0000, 32'h0,        0);

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset We", {31'd0, mem_we}, 32'd0);
    chk("reset BE", {28'd0, mem_be}, 32'd0);
    chk("reset A", {21'd0, mem_a}, 32'd0);
    chk("reset WD", mem_wd, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);
    chk("mem word0 after oor SW", mem[0], 32'd0);
    chk("mem word4", mem[4], 32'hAB345A78);
    chk("mem word8", mem[8], 32'h80010000);

    // Back-pressure: response held, second request ignored
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_op = 3'd5; req_addr = 32'h30; req_wdata = 32'h55AA55AA;
    we0 = we_cnt;
    @(posedge clk); #1;
    held = rsp_rdata;
    chk("stall rdata", held, 32'hAB345A78);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d rsp_valid", c), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d rdata", c), rsp_rdata, 32'hAB345A78);
      chk($sformatf("stall%0d req_ready", c), {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stall release req_ready", {31'd0, req_ready}, 32'd1);
    chk("stall release rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ignored request no write", we_cnt - we0, 32'd0);
    chk("ignored request mem", mem[12], 32'd0);
    @(posedge clk); #1;
    chk("ignored request not queued", {31'd0, rsp_valid}, 32'd0);

    // Reset in the ACCESS cycle of a store
    we0 = we_cnt;
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst access We", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst access no write", we_cnt - we0, 32'd0);
    chk("rst access mem", mem[16], 32'd0);
    chk("rst access idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rst access no rsp", {31'd0, rsp_valid}, 32'd0);

    // Reset in RESP drops the response
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst resp dropped", {31'd0, rsp_valid}, 32'd0);
    chk("rst resp rdata", rsp_rdata, 32'd0);
    chk("rst resp idle", {31'd0, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_dm_lsu
`default_nettype wire
